i2c_bus_event_detector: RTL and testbench

Front-end stage for the passive I2C sniffing/overwrite logic. It takes the raw open-drain SDA/SCL pins and synchronises and glitch-filters them. It then decodes bus conditions into single-cycle pulses (start, stop, data) plus the sampled bit. Downstream frame/overwrite logic consumes these pulses directly.

---
 rtl/i2c_bus_event_detector.sv | 98 +++++++++
 tb/tb_i2c_bus_event_detector.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_event_detector.sv
// i2c_bus_event_detector: synchronise and glitch-filter raw SDA/SCL, decode start/stop/data pulses.
// Optional SCL-low timeout is compiled in with `define I2C_SCL_TIMEOUT_EN.
module i2c_bus_event_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda,
  input  logic       scl,
  output logic       start,
  output logic       stop,
  output logic       data,
  output logic       data_bit,
  output logic [3:0] bit_idx,
  output logic       byte_done,
  output logic       bus_busy,
  output logic       scl_f,
  output logic       timeout
);
  localparam int FW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] s, f, p;
  logic [3:0] cnt;
  logic sda_f, start_c, stop_c, rise_c;
  assign s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    else begin
      sync_q[0] <= {scl, sda};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic [FW-1:0] fcnt;
    logic f_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        fcnt <= '0;
        f_q <= 1'b1;
      end else if (s[g] == f_q) fcnt <= '0;
      else if (fcnt == FW'(FILT_LEN - 1)) begin
        fcnt <= '0;
        f_q <= s[g];
      end else fcnt <= fcnt + 1'b1;
    assign f[g] = f_q;
  end
  assign sda_f = f[0];
  assign scl_f = f[1];
  assign bus_busy = (state == BUSY);
  // an SCL edge in the same cycle masks any SDA edge, so start/stop need SCL high on both sides
  assign start_c = p[1] & scl_f & p[0] & ~sda_f;
  assign stop_c = p[1] & scl_f & ~p[0] & sda_f;
  assign rise_c = ~p[1] & scl_f & bus_busy;
  always_comb state_n = start ? BUSY : (stop || timeout) ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      p <= 2'b11;
      start <= 1'b0;
      stop <= 1'b0;
      data <= 1'b0;
      byte_done <= 1'b0;
      data_bit <= 1'b0;
      bit_idx <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      p <= f;
      start <= start_c;
      stop <= stop_c;
      data <= rise_c;
      byte_done <= rise_c & (cnt == 4'd8);
      if (rise_c) begin
        data_bit <= sda_f;
        bit_idx <= cnt;
      end
      if (start || timeout) cnt <= '0;
      else if (rise_c) cnt <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
    end
`ifdef I2C_SCL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tcnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= bus_busy & ~scl_f & (tcnt == TW'(TIMEOUT_CYC - 1));
      if (scl_f) tcnt <= '0;
      else if (bus_busy && tcnt != TW'(TIMEOUT_CYC)) tcnt <= tcnt + 1'b1;
    end
`else
  assign timeout = 1'b0 & (TIMEOUT_CYC > 0);
`endif
endmodule

// File: tb/tb_i2c_bus_event_detector.sv
// tb_i2c_bus_event_detector: random and directed I2C pin stimulus against a behavioural model.
module tb_i2c_bus_event_detector;
  localparam int S = 2;
  localparam int F = 4;
  localparam int TO = 100;
  localparam int H = 10;
  logic clk = 1'b0, rst = 1'b1, sda = 1'b1, scl = 1'b1;
  logic start, stop, data, data_bit, byte_done, bus_busy, scl_f, timeout;
  logic [3:0] bit_idx;
  int n_chk = 0, n_fail = 0;
  i2c_bus_event_detector #(.SYNC_STAGES(S), .FILT_LEN(F), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .sda(sda), .scl(scl), .start(start), .stop(stop), .data(data),
    .data_bit(data_bit), .bit_idx(bit_idx), .byte_done(byte_done), .bus_busy(bus_busy),
    .scl_f(scl_f), .timeout(timeout));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, got, want);
    end
  endtask

  // behavioural model: pin samples are delayed S cycles, a line follows only after F
  // consecutive disagreeing samples, events are one cycle behind the filtered edges
  bit [1:0] hq[$];
  bit fq0[$], fq1[$];
  bit [1:0] mf, mp;
  bit m_start, m_stop, m_data, m_bit, m_bd, m_busy, m_to;
  int m_idx, m_nbits, m_low;

  function automatic void model_reset();
    hq = {};
    fq0 = {};
    fq1 = {};
    repeat (S) hq.push_back(2'b11);
    repeat (F) begin
      fq0.push_back(1'b1);
      fq1.push_back(1'b1);
    end
    mf = 2'b11;
    mp = 2'b11;
    {m_start, m_stop, m_data, m_bit, m_bd, m_busy, m_to} = '0;
    m_idx = 0;
    m_nbits = 0;
    m_low = 0;
  endfunction

  function automatic void model_step(input bit [1:0] pin);
    bit [1:0] syn;
    bit n_start, n_stop, n_rise, n_to, d0, d1;
    syn = hq.pop_front();
    hq.push_back(pin);
    n_start = mp[1] && mf[1] && mp[0] && !mf[0];
    n_stop = mp[1] && mf[1] && !mp[0] && mf[0];
    n_rise = !mp[1] && mf[1] && m_busy;
`ifdef I2C_SCL_TIMEOUT_EN
    n_to = m_busy && !mf[1] && (m_low == TO - 1);
    if (mf[1]) m_low = 0;
    else if (m_busy) m_low++;
`else
    n_to = 1'b0;
`endif
    m_bd = n_rise && (m_nbits % 9 == 8);
    if (n_rise) begin
      m_bit = mf[0];
      m_idx = m_nbits % 9;
      m_nbits++;
    end
    if (m_start) begin
      m_busy = 1'b1;
      m_nbits = 0;
    end else if (m_stop || m_to) begin
      m_busy = 1'b0;
      m_nbits = 0;
    end
    mp = mf;
    fq0.push_back(syn[0]);
    void'(fq0.pop_front());
    fq1.push_back(syn[1]);
    void'(fq1.pop_front());
    d0 = 1'b1;
    d1 = 1'b1;
    foreach (fq0[i]) if (fq0[i] == mf[0]) d0 = 1'b0;
    foreach (fq1[i]) if (fq1[i] == mf[1]) d1 = 1'b0;
    if (d0) mf[0] = syn[0];
    if (d1) mf[1] = syn[1];
    m_start = n_start;
    m_stop = n_stop;
    m_data = n_rise;
    m_to = n_to;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step({scl, sda});
    end
  end

  always @(negedge clk)
    if (!rst) begin
      chk("start", start, m_start);
      chk("stop", stop, m_stop);
      chk("data", data, m_data);
      chk("data_bit", data_bit, m_bit);
      chk("byte_done", byte_done, m_bd);
      chk("bus_busy", bus_busy, m_busy);
      chk("scl_f", scl_f, mf[1]);
      chk("timeout", timeout, m_to);
      if (m_data) chk("bit_idx", bit_idx, m_idx);
    end

  // observed pulse counts and data log for the hand-computed checks
  int c_start = 0, c_stop = 0, c_data = 0, c_bd = 0, c_to = 0;
  int dlog[$];
  bit prev_stop = 0, busy_at_stop = 0, busy_after_stop = 1;
  initial forever begin
    @(posedge clk);
    #1;
    if (prev_stop) busy_after_stop = bus_busy;
    if (stop) busy_at_stop = bus_busy;
    prev_stop = stop;
    c_start += int'(start);
    c_stop += int'(stop);
    c_bd += int'(byte_done);
    c_to += int'(timeout);
    if (data) begin
      c_data++;
      dlog.push_back({27'd0, data_bit, bit_idx});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input bit b, input bit g);
    sda = b;
    cyc(H);
    scl = 1'b1;
    cyc(3);
    if (g) begin
      sda = ~b;
      cyc($urandom_range(1, F - 1));
      sda = b;
    end
    cyc(H);
    scl = 1'b0;
    cyc(H);
  endtask
  task automatic do_start;
    sda = 1'b1;
    cyc(H);
    scl = 1'b1;
    cyc(H);
    sda = 1'b0;
    cyc(H);
    scl = 1'b0;
    cyc(H);
  endtask
  task automatic do_stop;
    sda = 1'b0;
    cyc(H);
    scl = 1'b1;
    cyc(H);
    sda = 1'b1;
    cyc(H);
  endtask

  initial begin
    int s0, s1, s2, lat;
    logic [8:0] exp_bits;
    exp_bits = 9'b101000010;
    cyc(3);
    chk("rst_start", start, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_idx", bit_idx, 0);
    chk("rst_scl_f", scl_f, 1);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;
    cyc(100);
    chk("idle_pulses", c_start + c_stop + c_data + c_to, 0);
    chk("idle_busy", bus_busy, 0);
    // byte 0xA1 with ACK=0
    s0 = c_start;
    s1 = c_stop;
    s2 = c_bd;
    dlog = {};
    do_start;
    chk("a1_busy", bus_busy, 1);
    for (int i = 0; i < 9; i++) send_bit(exp_bits[8-i], 1'b0);
    do_stop;
    cyc(H);
    chk("a1_starts", c_start - s0, 1);
    chk("a1_stops", c_stop - s1, 1);
    chk("a1_byte_done", c_bd - s2, 1);
    chk("a1_ndata", dlog.size() >= 9, 1);
    for (int i = 0; i < 9 && i < dlog.size(); i++) begin
      chk("a1_bit", dlog[i] >> 4, int'(exp_bits[8-i]));
      chk("a1_idx", dlog[i] & 15, i);
    end
    chk("busy_at_stop", busy_at_stop, 1);
    chk("busy_after_stop", busy_after_stop, 0);
    // glitch rejection then minimum accepted pulse latency
    s0 = c_start;
    sda = 1'b0;
    cyc(F - 1);
    sda = 1'b1;
    cyc(20);
    chk("glitch_start", c_start - s0, 0);
    sda = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (start && lat < 0) lat = k;
    end
    chk("start_latency", lat, S + F + 1);
    @(negedge clk);
    scl = 1'b0;
    cyc(H);
    do_stop;
    // repeated start after 5 bits
    do_start;
    repeat (5) send_bit(1'($urandom_range(0, 1)), 1'b0);
    s0 = c_start;
    dlog = {};
    do_start;
    send_bit(1'b1, 1'b0);
    chk("rs_start", c_start - s0, 1);
    chk("rs_busy", bus_busy, 1);
    chk("rs_ndata", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk("rs_idx_before", dlog[0] & 15, 5);
      chk("rs_idx_after", dlog[1] & 15, 0);
    end
    do_stop;
    // SDA and SCL toggled together
    do_start;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    s0 = c_start;
    s1 = c_stop;
    s2 = c_data;
    sda = 1'b0;
    scl = 1'b1;
    cyc(H);
    scl = 1'b0;
    cyc(H);
    chk("sim_data", c_data - s2, 1);
    chk("sim_startstop", (c_start - s0) + (c_stop - s1), 0);
    do_stop;
    // SCL held low mid-byte
    do_start;
    repeat (3) send_bit(1'b1, 1'b0);
    s0 = c_to;
    cyc(TO + 50);
    s2 = c_data;
    repeat (2) send_bit(1'b0, 1'b0);
`ifdef I2C_SCL_TIMEOUT_EN
    chk("to_pulse", c_to - s0, 1);
    chk("to_busy", bus_busy, 0);
    chk("to_data", c_data - s2, 0);
`else
    chk("to_pulse", c_to - s0, 0);
    chk("to_busy", bus_busy, 1);
    chk("to_data", c_data - s2, 2);
`endif
    do_stop;
    // random transactions with sub-filter glitches
    for (int t = 0; t < 30; t++) begin
      do_start;
      repeat ($urandom_range(1, 18)) send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        do_start;
        repeat ($urandom_range(1, 9)) send_bit(1'($urandom_range(0, 1)), 1'b0);
      end
      if ($urandom_range(0, 4) != 0) do_stop;
    end
    // raw pin noise, with occasional long SCL-low holds
    for (int n = 0; n < 300; n++) begin
      sda = 1'($urandom_range(0, 1));
      scl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        scl = 1'b0;
        cyc($urandom_range(TO - 5, TO + 30));
      end else cyc($urandom_range(1, 12));
    end
    scl = 1'b0;
    cyc(H);
    do_stop;
    cyc(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
